// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction prefetch queue between the PC/ROM fetch stage and ID.
//   Buffers up to DEPTH {pc, inst} pairs so fetch keeps running while
//   decode stalls, back-pressures fetch via fetch_ready, and flushes on a
//   taken branch while optionally retaining the delay-slot instruction.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fetch_valid/pc/inst      incoming fetch beat
//   fetch_ready              queue can accept a beat (not full)
//   id_ready                 ID consumes the head entry this cycle
//   id_valid/pc/inst         head entry (pc/inst forced to 0 when empty)
//   flush                    taken branch in ID
//   count                    occupancy
module inst_fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_pc,
  input  logic [31:0]              fetch_inst,
  output logic                     fetch_ready,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_inst,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt_q;
  logic [63:0]   head;
  logic          push;
  logic          pop;
  logic          wr_en;

  assign count       = cnt_q;
  assign fetch_ready = (cnt_q < CW'(DEPTH));
  assign id_valid    = (cnt_q != '0);
  assign head        = mem[rd_ptr];
  assign id_pc       = id_valid ? head[63:32] : '0;
  assign id_inst     = id_valid ? head[31:0]  : '0;

  assign push = fetch_valid & fetch_ready;
  assign pop  = id_valid & id_ready & ~flush;

  // During a flush the incoming beat is only kept when the queue is empty
  // and it is itself the delay-slot instruction.
  assign wr_en = push & ~rst & (~flush | (DELAY_SLOT && (cnt_q == '0)));

  // Storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {fetch_pc, fetch_inst};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      if (DELAY_SLOT) begin
        if (id_valid) begin
          // Keep the head only: it is the delay slot.
          wr_ptr <= rd_ptr + AW'(1);
          cnt_q  <= CW'(1);
        end else if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          cnt_q  <= CW'(1);
        end
      end else begin
        wr_ptr <= rd_ptr;
        cnt_q  <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
